// File: rtl/pb_first_press_arbiter.sv
// First-press arbiter for N player pushbuttons: synchronises, edge-detects and
// latches the first press (or a same-cycle tie) until rst or clear.
module pb_first_press_arbiter #(
    parameter int N_PLAYERS      = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCKOUT_CYCLES = 4,
    localparam int W             = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [N_PLAYERS-1:0] pb,
    output logic                 ready,
    output logic                 push,
    output logic                 push_pulse,
    output logic                 tie,
    output logic [W-1:0]         winner,
    output logic [N_PLAYERS-1:0] winner_onehot,
    output logic [N_PLAYERS-1:0] tie_mask,
    output logic                 right
);

    typedef enum logic [1:0] {
        ST_LOCKOUT,
        ST_ARMED,
        ST_WON,
        ST_TIE
    } state_t;

    // LOCKOUT_CYCLES of 0 and 1 both arm on the first edge after rst/clear.
    localparam logic [15:0] LOCK_LAST =
        (LOCKOUT_CYCLES > 1) ? 16'(LOCKOUT_CYCLES - 1) : 16'd0;

    state_t                 state_q, state_d;
    logic [15:0]            lock_cnt_q, lock_cnt_d;
    logic [N_PLAYERS-1:0]   sync_q [SYNC_STAGES];
    logic [N_PLAYERS-1:0]   sync_d [SYNC_STAGES];
    logic [N_PLAYERS-1:0]   prev_q, prev_d;
    logic [N_PLAYERS-1:0]   onehot_q, onehot_d;
    logic [N_PLAYERS-1:0]   tie_mask_q, tie_mask_d;
    logic [W-1:0]           winner_q, winner_d;
    logic                   push_pulse_q, push_pulse_d;

    logic [N_PLAYERS-1:0]   s;
    logic [N_PLAYERS-1:0]   rise;
    logic [4:0]             rise_count;
    logic [W-1:0]           rise_idx;

    always_comb begin
        sync_d[0] = pb;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~prev_q;
    // Reload on clear is the same as normal tracking, so prev always follows s.
    assign prev_d = s;

    always_comb begin
        rise_count = '0;
        rise_idx   = '0;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            rise_count = rise_count + 5'(rise[i]);
            if (rise[i]) begin
                rise_idx = W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        winner_d     = winner_q;
        onehot_d     = onehot_q;
        tie_mask_d   = tie_mask_q;
        push_pulse_d = 1'b0;

        if (clear) begin
            state_d    = ST_LOCKOUT;
            lock_cnt_d = '0;
            winner_d   = '0;
            onehot_d   = '0;
            tie_mask_d = '0;
        end else begin
            unique case (state_q)
                ST_LOCKOUT: begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = ST_ARMED;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 16'd1;
                    end
                end
                ST_ARMED: begin
                    if (rise_count == 5'd1) begin
                        state_d      = ST_WON;
                        winner_d     = rise_idx;
                        onehot_d     = rise;
                        push_pulse_d = 1'b1;
                    end else if (rise_count >= 5'd2) begin
                        state_d    = ST_TIE;
                        tie_mask_d = rise;
                    end
                end
                ST_WON, ST_TIE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_LOCKOUT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOCKOUT;
            lock_cnt_q   <= '0;
            prev_q       <= '0;
            winner_q     <= '0;
            onehot_q     <= '0;
            tie_mask_q   <= '0;
            push_pulse_q <= 1'b0;
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            prev_q       <= prev_d;
            winner_q     <= winner_d;
            onehot_q     <= onehot_d;
            tie_mask_q   <= tie_mask_d;
            push_pulse_q <= push_pulse_d;
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign ready         = (state_q == ST_ARMED);
    assign push          = (state_q == ST_WON);
    assign tie           = (state_q == ST_TIE);
    assign push_pulse    = push_pulse_q;
    assign winner        = winner_q;
    assign winner_onehot = onehot_q;
    assign tie_mask      = tie_mask_q;
    assign right         = onehot_q[1];

endmodule

// File: tb/tb_pb_first_press_arbiter.sv
// Bench for pb_first_press_arbiter: two instances (N=4/L=4 and N=2/L=0) against
// a delay-line plus elapsed-cycle reference model, directed then random stimulus.
module tb_pb_first_press_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear_a, clear_b;
    logic [3:0] pb_a;
    logic [1:0] pb_b;

    logic       ready_a, push_a, pulse_a, tie_a, right_a;
    logic [1:0] winner_a;
    logic [3:0] oh_a, tm_a;
    logic       ready_b, push_b, pulse_b, tie_b, right_b;
    logic [0:0] winner_b;
    logic [1:0] oh_b, tm_b;

    pb_first_press_arbiter #(.N_PLAYERS(4), .SYNC_STAGES(2), .LOCKOUT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clear_a), .pb(pb_a),
        .ready(ready_a), .push(push_a), .push_pulse(pulse_a), .tie(tie_a),
        .winner(winner_a), .winner_onehot(oh_a), .tie_mask(tm_a), .right(right_a)
    );

    pb_first_press_arbiter #(.N_PLAYERS(2), .SYNC_STAGES(3), .LOCKOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b), .pb(pb_b),
        .ready(ready_b), .push(push_b), .push_pulse(pulse_b), .tie(tie_b),
        .winner(winner_b), .winner_onehot(oh_b), .tie_mask(tm_b), .right(right_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pb history as a delay line, plus edges elapsed since rst/clear.
    int          s_of [2] = '{2, 3};
    int          l_of [2] = '{4, 0};
    int          age  [2];
    bit          done [2];
    bit          m_pulse [2];
    logic [15:0] m_oh [2];
    logic [15:0] m_tm [2];
    logic [15:0] hist [2][8];

    function automatic int arm_age(input int k);
        return (l_of[k] == 0) ? 1 : l_of[k];
    endfunction

    function automatic int idx_of(input logic [15:0] v);
        int r = 0;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_step(input int k, input bit r, input bit c, input logic [15:0] p);
        logic [15:0] s, pv, rise;
        if (r) begin
            for (int j = 0; j < 8; j++) hist[k][j] = '0;
            age[k] = 0; done[k] = 0; m_pulse[k] = 0; m_oh[k] = '0; m_tm[k] = '0;
            return;
        end
        s    = hist[k][s_of[k]-1];
        pv   = hist[k][s_of[k]];
        rise = s & ~pv;
        m_pulse[k] = 0;
        if (c) begin
            age[k] = 0; done[k] = 0; m_oh[k] = '0; m_tm[k] = '0;
        end else begin
            if (!done[k] && age[k] >= arm_age(k)) begin
                if ($countones(rise) == 1) begin
                    done[k] = 1; m_oh[k] = rise; m_pulse[k] = 1;
                end else if ($countones(rise) >= 2) begin
                    done[k] = 1; m_tm[k] = rise;
                end
            end
            if (age[k] < 1000) age[k]++;
        end
        for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = p;
    endtask

    always @(posedge clk) begin
        model_step(0, rst, clear_a, {12'd0, pb_a});
        model_step(1, rst, clear_b, {14'd0, pb_b});
    end

    task automatic check_inst(input int k, input string pfx,
                              input logic rdy, input logic psh, input logic pls,
                              input logic ti, input logic rt,
                              input logic [15:0] win, input logic [15:0] oh,
                              input logic [15:0] tm);
        bit e_rdy;
        e_rdy = !done[k] && (age[k] >= arm_age(k));
        check({pfx, "_ready"},    32'(rdy), 32'(e_rdy));
        check({pfx, "_push"},     32'(psh), 32'(done[k] && m_oh[k] != 0));
        check({pfx, "_pulse"},    32'(pls), 32'(m_pulse[k]));
        check({pfx, "_tie"},      32'(ti),  32'(done[k] && m_tm[k] != 0));
        check({pfx, "_winner"},   32'(win), 32'(idx_of(m_oh[k])));
        check({pfx, "_onehot"},   32'(oh),  32'(m_oh[k]));
        check({pfx, "_tie_mask"}, 32'(tm),  32'(m_tm[k]));
        check({pfx, "_right"},    32'(rt),  32'(m_oh[k][1]));
        check({pfx, "_exclusive"}, 32'(psh & ti), 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        check_inst(0, "a", ready_a, push_a, pulse_a, tie_a, right_a,
                   {14'd0, winner_a}, {12'd0, oh_a}, {12'd0, tm_a});
        check_inst(1, "b", ready_b, push_b, pulse_b, tie_b, right_b,
                   {15'd0, winner_b}, {14'd0, oh_b}, {14'd0, tm_b});
    endtask

    initial begin
        rst = 1'b1; clear_a = 1'b0; clear_b = 1'b0; pb_a = '0; pb_b = '0;
        repeat (3) tick();
        check("rst_push", 32'(push_a), 32'd0);
        check("rst_onehot", 32'(oh_a), 32'd0);
        rst = 1'b0;

        // Lockout window on A; B has none.
        tick();
        check("lock_ready_a", 32'(ready_a), 32'd0);
        check("l0_ready_b", 32'(ready_b), 32'd1);
        repeat (2) begin
            tick();
            check("lock_ready_a", 32'(ready_a), 32'd0);
        end
        tick();
        check("armed_ready_a", 32'(ready_a), 32'd1);

        // Single press on player 2.
        pb_a = 4'b0100;
        repeat (2) tick();
        check("pre_push_a", 32'(push_a), 32'd0);
        tick();
        check("win_push_a", 32'(push_a), 32'd1);
        check("win_idx_a", 32'(winner_a), 32'd2);
        check("win_oh_a", 32'(oh_a), 32'h4);
        check("win_pulse_a", 32'(pulse_a), 32'd1);
        tick();
        check("pulse_drop_a", 32'(pulse_a), 32'd0);
        pb_a = 4'b0101;
        repeat (5) tick();
        check("late_press_a", 32'(winner_a), 32'd2);

        // Simultaneous press -> tie.
        pb_a = '0; clear_a = 1'b1; tick(); clear_a = 1'b0;
        repeat (6) tick();
        pb_a = 4'b1010;
        repeat (4) tick();
        check("tie_a", 32'(tie_a), 32'd1);
        check("tie_mask_a", 32'(tm_a), 32'ha);
        check("tie_push_a", 32'(push_a), 32'd0);
        check("tie_winner_a", 32'(winner_a), 32'd0);

        // Button held across clear and lockout cannot win.
        pb_a = 4'b0001;
        repeat (3) tick();
        clear_a = 1'b1; tick(); clear_a = 1'b0;
        repeat (8) tick();
        check("held_push_a", 32'(push_a), 32'd0);
        check("held_ready_a", 32'(ready_a), 32'd1);
        pb_a = '0;
        repeat (3) tick();
        pb_a = 4'b0001;
        repeat (4) tick();
        check("repress_push_a", 32'(push_a), 32'd1);
        check("repress_oh_a", 32'(oh_a), 32'h1);

        // Clear coincides with a rise reaching the edge detector.
        pb_a = '0; clear_a = 1'b1; tick(); clear_a = 1'b0;
        repeat (6) tick();
        pb_a = 4'b1000;
        repeat (2) tick();
        clear_a = 1'b1; tick(); clear_a = 1'b0;
        check("clr_rise_push_a", 32'(push_a), 32'd0);
        check("clr_rise_ready_a", 32'(ready_a), 32'd0);
        repeat (3) begin
            tick();
            check("clr_lock_ready_a", 32'(ready_a), 32'd0);
        end
        tick();
        check("clr_armed_ready_a", 32'(ready_a), 32'd1);
        repeat (4) tick();
        check("clr_held_push_a", 32'(push_a), 32'd0);

        // rst with clear mid-WON.
        pb_a = '0;
        repeat (3) tick();
        pb_a = 4'b0010;
        repeat (4) tick();
        check("won_idx_a", 32'(winner_a), 32'd1);
        rst = 1'b1; clear_a = 1'b1; tick();
        check("rst_won_push_a", 32'(push_a), 32'd0);
        check("rst_won_oh_a", 32'(oh_a), 32'd0);
        check("rst_won_ready_a", 32'(ready_a), 32'd0);
        rst = 1'b0; clear_a = 1'b0; pb_a = '0;
        tick();
        check("l0_rearm_b", 32'(ready_b), 32'd1);

        // Two-player instance.
        pb_b = 2'b10;
        repeat (3) tick();
        check("pre_push_b", 32'(push_b), 32'd0);
        tick();
        check("right_b", 32'(right_b), 32'd1);
        check("winner_b", 32'(winner_b), 32'd1);
        clear_b = 1'b1; pb_b = '0; tick(); clear_b = 1'b0;
        repeat (4) tick();
        pb_b = 2'b01;
        repeat (5) tick();
        check("left_right_b", 32'(right_b), 32'd0);
        check("left_push_b", 32'(push_b), 32'd1);
        check("left_winner_b", 32'(winner_b), 32'd0);

        // Randomised phase, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] fa;
            logic [1:0] fb;
            tick();
            for (int i = 0; i < 4; i++) fa[i] = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < 2; i++) fb[i] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) fa = 4'b1111 & {4{pb_a == 4'd0}} & 4'($urandom);
            pb_a    = pb_a ^ fa;
            pb_b    = pb_b ^ fb;
            clear_a = ($urandom_range(0, 39) == 0);
            clear_b = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
